// File: rtl/axi_multi_inval_filter.sv
// axi_multi_inval_filter
//   Multi-port, burst-aware write-invalidation filter. Sits between NrPorts
//   AXI write masters and the interconnect. Each AW burst accepted while
//   coherence is enabled produces one invalidation per L1 D-cache line it
//   touches. The matching B response is held back until every invalidation
//   for that burst has been acknowledged.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   en_i             coherence enable, captured with each AW handshake
//   slv_req_i/resp_o upstream (master-facing) AXI port per channel index
//   mst_req_o/resp_i downstream (interconnect-facing) AXI port
//   inval_addr_o     line-aligned invalidation address
//   inval_valid_o    invalidation request valid (held until ready)
//   inval_ready_i    invalidation accepted
//   busy_o           any FIFO non-empty or invalidation in flight

package axi_multi_inval_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_chan_t;

  typedef aw_chan_t ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } resp_t;
endpackage

module axi_multi_inval_filter
  import axi_multi_inval_pkg::*;
#(
  parameter int unsigned NrPorts     = 2,
  parameter int unsigned MaxTxns     = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned L1LineWidth = 16,
  parameter type aw_chan_t = axi_multi_inval_pkg::aw_chan_t,
  parameter type req_t     = axi_multi_inval_pkg::req_t,
  parameter type resp_t    = axi_multi_inval_pkg::resp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  req_t                 slv_req_i  [NrPorts],
  output resp_t                slv_resp_o [NrPorts],
  output req_t                 mst_req_o  [NrPorts],
  input  resp_t                mst_resp_i [NrPorts],
  output logic [AddrWidth-1:0] inval_addr_o,
  output logic                 inval_valid_o,
  input  logic                 inval_ready_i,
  output logic                 busy_o
);

  localparam int unsigned LineShift = $clog2(L1LineWidth);
  localparam int unsigned LineW     = AddrWidth - LineShift;
  // Widest burst is 256 beats of 128 bytes; one extra bit covers an
  // unaligned start spilling into one more line.
  localparam int unsigned NlW       = $clog2(256 * 128 / L1LineWidth) + 1;
  localparam int unsigned DoneW     = $clog2(MaxTxns) + 1;
  localparam int unsigned CntW      = $clog2(MaxTxns + 1);
  localparam int unsigned PtrW      = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int unsigned PortW     = (NrPorts > 1) ? $clog2(NrPorts) : 1;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic {IDLE, ISSUE} state_e;

  // Number of bytes covered by one burst.
  function automatic logic [15:0] span_bytes(input logic [7:0] len,
                                             input logic [2:0] size,
                                             input logic [1:0] burst);
    if (burst == BurstFixed) return 16'd1 << size;
    return ({8'd0, len} + 16'd1) << size;
  endfunction

  // WRAP bursts cover the window aligned down to the total burst size.
  function automatic logic [AddrWidth-1:0] span_start(input logic [AddrWidth-1:0] addr,
                                                      input logic [15:0]          bytes,
                                                      input logic [1:0]           burst);
    logic [AddrWidth-1:0] mask;
    mask = AddrWidth'(bytes) - AddrWidth'(1);
    return (burst == BurstWrap) ? (addr & ~mask) : addr;
  endfunction

  // Line count uses one extra address bit so a span crossing the top of
  // the address space still counts every line.
  function automatic logic [NlW-1:0] span_nlines(input logic [AddrWidth-1:0] start,
                                                 input logic [15:0]          bytes);
    logic [AddrWidth:0] last_byte;
    logic [AddrWidth:0] n;
    last_byte = {1'b0, start} + (AddrWidth+1)'(bytes) - (AddrWidth+1)'(1);
    n = (last_byte >> LineShift) - ({1'b0, start} >> LineShift) + (AddrWidth+1)'(1);
    return NlW'(n);
  endfunction

  logic [LineW-1:0] fifo_line [NrPorts][MaxTxns];
  logic [NlW-1:0]   fifo_nl   [NrPorts][MaxTxns];
  logic             fifo_en   [NrPorts][MaxTxns];
  logic [PtrW-1:0]  wptr      [NrPorts];
  logic [PtrW-1:0]  rptr      [NrPorts];
  logic [CntW-1:0]  count     [NrPorts];
  logic [DoneW-1:0] done_cnt  [NrPorts];

  logic [NrPorts-1:0] full, nonempty, done_nz, aw_hs, b_hs, pop;
  logic [LineW-1:0]   push_line [NrPorts];
  logic [NlW-1:0]     push_nl   [NrPorts];
  aw_chan_t           aw_in     [NrPorts];

  state_e           state_q, state_d;
  logic [PortW-1:0] rr_q, rr_d, sel_q, sel_d, pick;
  logic [LineW-1:0] line_q, line_d;
  logic [NlW-1:0]   rem_q, rem_d;
  logic             found;

  // Channel pass-through with AW and B gating, plus entry computation.
  always_comb begin
    full     = '0;
    nonempty = '0;
    done_nz  = '0;
    aw_hs    = '0;
    b_hs     = '0;
    for (int p = 0; p < NrPorts; p++) begin
      full[p]     = (count[p] == CntW'(MaxTxns));
      nonempty[p] = (count[p] != '0);
      done_nz[p]  = (done_cnt[p] != '0);

      mst_req_o[p]          = slv_req_i[p];
      mst_req_o[p].aw_valid = slv_req_i[p].aw_valid & ~full[p];
      mst_req_o[p].b_ready  = slv_req_i[p].b_ready & done_nz[p];

      slv_resp_o[p]          = mst_resp_i[p];
      slv_resp_o[p].aw_ready = mst_resp_i[p].aw_ready & ~full[p];
      slv_resp_o[p].b_valid  = mst_resp_i[p].b_valid & done_nz[p];

      aw_hs[p] = slv_req_i[p].aw_valid & mst_resp_i[p].aw_ready & ~full[p];
      b_hs[p]  = mst_resp_i[p].b_valid & slv_req_i[p].b_ready & done_nz[p];

      aw_in[p]     = slv_req_i[p].aw;
      push_line[p] = LineW'(span_start(AddrWidth'(aw_in[p].addr),
                                       span_bytes(aw_in[p].len, aw_in[p].size, aw_in[p].burst),
                                       aw_in[p].burst) >> LineShift);
      push_nl[p]   = span_nlines(span_start(AddrWidth'(aw_in[p].addr),
                                            span_bytes(aw_in[p].len, aw_in[p].size, aw_in[p].burst),
                                            aw_in[p].burst),
                                 span_bytes(aw_in[p].len, aw_in[p].size, aw_in[p].burst));
    end
  end

  // Invalidation FSM: next state and pop decisions.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    line_d  = line_q;
    rem_d   = rem_q;
    pop     = '0;
    found   = 1'b0;
    pick    = '0;
    unique case (state_q)
      IDLE: begin
        for (int unsigned i = 0; i < NrPorts; i++) begin
          if (!found && nonempty[(32'(rr_q) + i) % NrPorts]) begin
            found = 1'b1;
            pick  = PortW'((32'(rr_q) + i) % NrPorts);
          end
        end
        if (found) begin
          if (!fifo_en[pick][rptr[pick]]) begin
            // Coherence was off for this burst: retire it immediately.
            pop[pick] = 1'b1;
          end else begin
            sel_d   = pick;
            line_d  = fifo_line[pick][rptr[pick]];
            rem_d   = fifo_nl[pick][rptr[pick]];
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (inval_ready_i) begin
          if (rem_q > NlW'(1)) begin
            line_d = line_q + LineW'(1);
            rem_d  = rem_q - NlW'(1);
          end else begin
            pop[sel_q] = 1'b1;
            rr_d       = (32'(sel_q) == NrPorts - 1) ? '0 : sel_q + PortW'(1);
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inval_valid_o = (state_q == ISSUE);
  assign inval_addr_o  = (state_q == ISSUE) ? (AddrWidth'(line_q) << LineShift) : '0;
  assign busy_o        = (|nonempty) | (state_q == ISSUE);

  // Control state: FSM, arbitration pointer, FIFO pointers, done counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      for (int p = 0; p < NrPorts; p++) begin
        wptr[p]     <= '0;
        rptr[p]     <= '0;
        count[p]    <= '0;
        done_cnt[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      for (int p = 0; p < NrPorts; p++) begin
        if (aw_hs[p]) wptr[p] <= (32'(wptr[p]) == MaxTxns - 1) ? '0 : wptr[p] + PtrW'(1);
        if (pop[p])   rptr[p] <= (32'(rptr[p]) == MaxTxns - 1) ? '0 : rptr[p] + PtrW'(1);
        unique case ({aw_hs[p], pop[p]})
          2'b10:   count[p] <= count[p] + CntW'(1);
          2'b01:   count[p] <= count[p] - CntW'(1);
          default: count[p] <= count[p];
        endcase
        unique case ({pop[p], b_hs[p]})
          2'b10:   done_cnt[p] <= done_cnt[p] + DoneW'(1);
          2'b01:   done_cnt[p] <= done_cnt[p] - DoneW'(1);
          default: done_cnt[p] <= done_cnt[p];
        endcase
      end
    end
  end

  // Datapath registers (no reset needed; qualified by control state).
  always_ff @(posedge clk_i) begin
    line_q <= line_d;
    rem_q  <= rem_d;
    sel_q  <= sel_d;
    for (int p = 0; p < NrPorts; p++) begin
      if (aw_hs[p]) begin
        fifo_line[p][wptr[p]] <= push_line[p];
        fifo_nl[p][wptr[p]]   <= push_nl[p];
        fifo_en[p][wptr[p]]   <= en_i;
      end
    end
  end

endmodule

// File: tb/tb_axi_multi_inval_filter.sv
module tb_axi_multi_inval_filter;
  import axi_multi_inval_pkg::*;

  localparam int NP = 2;
  localparam int MT = 4;
  localparam int LW = 16;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  req_t        slv_req  [NP];
  resp_t       slv_resp [NP];
  req_t        mst_req  [NP];
  resp_t       mst_resp [NP];
  logic [63:0] inval_addr;
  logic        inval_valid;
  logic        inval_ready;
  logic        busy;

  axi_multi_inval_filter #(
    .NrPorts(NP), .MaxTxns(MT), .AddrWidth(64), .L1LineWidth(LW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp),
    .inval_addr_o(inval_addr), .inval_valid_o(inval_valid),
    .inval_ready_i(inval_ready), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [63:0] got[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < NP; p++) begin
      slv_req[p]           = '0;
      mst_resp[p]          = '0;
      mst_resp[p].aw_ready = 1'b1;
      mst_resp[p].w_ready  = 1'b1;
      mst_resp[p].ar_ready = 1'b1;
    end
    en          = 1'b0;
    inval_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_aw(input int p, input logic [63:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    slv_req[p].aw.addr  = addr;
    slv_req[p].aw.len   = len;
    slv_req[p].aw.size  = size;
    slv_req[p].aw.burst = burst;
    slv_req[p].aw_valid = 1'b1;
  endtask

  task automatic send_aw(input int p, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit hs = 1'b0;
    set_aw(p, addr, len, size, burst);
    for (int i = 0; i < 60 && !hs; i++) begin
      @(negedge clk);
      hs = slv_resp[p].aw_ready;
      tick();
    end
    slv_req[p].aw_valid = 1'b0;
    check("aw_accept", hs, 1);
  endtask

  // Acknowledge every invalidation until the filter goes idle.
  task automatic collect(input int max_cyc);
    bit idle = 1'b0;
    got.delete();
    inval_ready = 1'b1;
    for (int i = 0; i < max_cyc && !idle; i++) begin
      @(negedge clk);
      if (inval_valid) got.push_back(inval_addr);
      if (!busy) idle = 1'b1;
      tick();
    end
    check("drain_idle", idle, 1);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
    int          exp_n;
  } vec_t;

  vec_t vt[9];

  // Reference model for the random phase.
  logic [63:0] ql [NP][$];
  int          qc [NP][$];
  int done_m[NP], bfwd[NP], awcnt[NP], pend[NP];
  bit bv[NP], aw_drop[NP];
  int cur;

  task automatic retire(input int p);
    while (qc[p].size() > 0 && qc[p][0] == 0) begin
      void'(qc[p].pop_front());
      done_m[p]++;
    end
  endtask

  task automatic model_push(input int p, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit e);
    longint unsigned bytes;
    logic [63:0] st, ln, prev;
    int n = 0;
    bytes = (burst == FIXED) ? (64'd1 << size) : ((64'(len) + 1) << size);
    st    = (burst == WRAP) ? (addr / bytes) * bytes : addr;
    prev  = '0;
    if (e) begin
      for (longint unsigned k = 0; k < bytes; k++) begin
        ln = ((st + k) / LW) * LW;
        if (n == 0 || ln != prev) begin
          ql[p].push_back(ln);
          n++;
          prev = ln;
        end
      end
    end
    qc[p].push_back(n);
    retire(p);
  endtask

  task automatic model_ack(input logic [63:0] a);
    int hit = -1;
    for (int p = 0; p < NP; p++)
      if (hit < 0 && ql[p].size() > 0 && ql[p][0] == a && (cur < 0 || cur == p)) hit = p;
    check("inval_order", hit >= 0, 1);
    if (hit >= 0) begin
      void'(ql[hit].pop_front());
      qc[hit][0] = qc[hit][0] - 1;
      if (qc[hit][0] == 0) begin
        cur = -1;
        retire(hit);
      end else begin
        cur = hit;
      end
    end
  endtask

  initial begin
    vt[0] = '{64'h1008, 8'd3, 3'd3, INCR, 64'h1000, 64'h1020, 3};
    vt[1] = '{64'h2034, 8'd3, 3'd2, WRAP, 64'h2030, 64'h2030, 1};
    vt[2] = '{64'h300F, 8'd7, 3'd0, FIXED, 64'h3000, 64'h3000, 1};
    vt[3] = '{64'h300F, 8'd0, 3'd3, FIXED, 64'h3000, 64'h3010, 2};
    vt[4] = '{64'h4000, 8'd0, 3'd4, INCR, 64'h4000, 64'h4000, 1};
    vt[5] = '{64'h4001, 8'd15, 3'd3, INCR, 64'h4000, 64'h4080, 9};
    vt[6] = '{64'h5074, 8'd7, 3'd3, WRAP, 64'h5040, 64'h5070, 4};
    vt[7] = '{64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, INCR, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 2};
    vt[8] = '{64'h8, 8'd255, 3'd7, INCR, 64'h0, 64'h8000, 2049};

    // Reset state and pass-through.
    do_reset();
    slv_req[1].ar_valid = 1'b1;
    slv_req[1].ar.addr  = 64'hABC0;
    mst_resp[1].r_valid = 1'b1;
    mst_resp[1].r.data  = 64'h55AA;
    @(negedge clk);
    check("rst_inval_valid", inval_valid, 0);
    check("rst_inval_addr", inval_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_aw_ready", slv_resp[0].aw_ready, 1);
    check("ar_pass", {mst_req[1].ar_valid, mst_req[1].ar.addr[15:0]}, {1'b1, 16'hABC0});
    check("r_pass", slv_resp[1].r.data, 64'h55AA);
    tick();

    // Span table.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      en = 1'b1;
      send_aw(0, vt[v].addr, vt[v].len, vt[v].size, vt[v].burst);
      collect(5000);
      check($sformatf("tbl%0d_n", v), got.size(), vt[v].exp_n);
      if (got.size() > 0) begin
        check($sformatf("tbl%0d_first", v), got[0], vt[v].exp_first);
        check($sformatf("tbl%0d_last", v), got[got.size()-1], vt[v].exp_last);
      end
    end

    // B withheld until the last of three acknowledgments.
    begin
      int acks = 0;
      int b_at = -1;
      do_reset();
      en = 1'b1;
      mst_resp[0].b_valid = 1'b1;
      slv_req[0].b_ready  = 1'b1;
      inval_ready = 1'b1;
      send_aw(0, 64'h1008, 8'd3, 3'd3, INCR);
      for (int i = 0; i < 40 && b_at < 0; i++) begin
        @(negedge clk);
        if (slv_resp[0].b_valid) b_at = acks;
        if (inval_valid && inval_ready) acks++;
        tick();
      end
      check("b_after_last_ack", b_at, 3);
      @(negedge clk);
      check("b_regated", slv_resp[0].b_valid, 0);
      tick();
    end

    // Coherence disabled: no invalidation, B forwarded after the pop.
    do_reset();
    mst_resp[0].b_valid = 1'b1;
    slv_req[0].b_ready  = 1'b1;
    inval_ready = 1'b1;
    send_aw(0, 64'h1234, 8'd0, 3'd0, INCR);
    @(negedge clk);
    check("en0_b_held", slv_resp[0].b_valid, 0);
    check("en0_no_inval", inval_valid, 0);
    tick();
    @(negedge clk);
    check("en0_b_fwd", slv_resp[0].b_valid, 1);
    check("en0_mst_b_ready", mst_req[0].b_ready, 1);
    check("en0_no_inval2", inval_valid, 0);
    tick();

    // Simultaneous AWs on both ports, then round-robin fairness.
    do_reset();
    en = 1'b1;
    set_aw(0, 64'h100, 8'd0, 3'd0, INCR);
    set_aw(1, 64'h200, 8'd0, 3'd0, INCR);
    @(negedge clk);
    tick();
    slv_req[0].aw_valid = 1'b0;
    slv_req[1].aw_valid = 1'b0;
    collect(50);
    check("rr_n", got.size(), 2);
    if (got.size() == 2) begin
      check("rr_first", got[0], 64'h100);
      check("rr_second", got[1], 64'h200);
    end
    inval_ready = 1'b0;
    send_aw(0, 64'h100, 8'd0, 3'd0, INCR);
    tick();
    set_aw(1, 64'h200, 8'd0, 3'd0, INCR);
    set_aw(0, 64'h180, 8'd0, 3'd0, INCR);
    @(negedge clk);
    tick();
    slv_req[0].aw_valid = 1'b0;
    slv_req[1].aw_valid = 1'b0;
    collect(50);
    check("fair_n", got.size(), 3);
    if (got.size() == 3) begin
      check("fair_a", got[0], 64'h100);
      check("fair_b", got[1], 64'h200);
      check("fair_c", got[2], 64'h180);
    end

    // Full FIFO stalls the fifth AW; it is accepted the cycle after a pop.
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 4; k++) send_aw(0, 64'h1000 + 64'(k) * 64'h10, 8'd0, 3'd0, INCR);
    set_aw(0, 64'h1040, 8'd0, 3'd0, INCR);
    @(negedge clk);
    check("full_aw_ready", slv_resp[0].aw_ready, 0);
    check("full_mst_aw_valid", mst_req[0].aw_valid, 0);
    tick();
    tick();
    inval_ready = 1'b1;
    @(negedge clk);
    check("pop_no_bypass", slv_resp[0].aw_ready, 0);
    tick();
    @(negedge clk);
    check("aw_after_pop", slv_resp[0].aw_ready, 1);
    tick();
    slv_req[0].aw_valid = 1'b0;
    collect(50);
    check("full_rest_n", got.size(), 4);
    if (got.size() == 4) check("full_fifth", got[3], 64'h1040);

    // Reset in the middle of a two-line burst.
    do_reset();
    en = 1'b1;
    mst_resp[0].b_valid = 1'b1;
    slv_req[0].b_ready  = 1'b1;
    send_aw(0, 64'h8, 8'd1, 3'd3, INCR);
    tick();
    @(negedge clk);
    check("pre_rst_valid", inval_valid, 1);
    check("pre_rst_addr", inval_addr, 64'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", inval_valid, 0);
    check("post_rst_addr", inval_addr, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_b", slv_resp[0].b_valid, 0);
    inval_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("post_rst_b_later", slv_resp[0].b_valid, 0);
    check("post_rst_busy_later", busy, 0);
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    cur = -1;
    for (int p = 0; p < NP; p++) begin
      ql[p].delete();
      qc[p].delete();
      done_m[p] = 0; bfwd[p] = 0; awcnt[p] = 0; pend[p] = 0; bv[p] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if (!slv_req[p].aw_valid && cyc < 2400 && (awcnt[p] - bfwd[p]) < 6 &&
            $urandom_range(0, 3) == 0) begin
          logic [1:0] bt;
          logic [7:0] ln;
          bt = 2'($urandom_range(0, 2));
          if (bt == WRAP) ln = 8'((1 << $urandom_range(1, 3)) - 1);
          else ln = 8'($urandom_range(0, 7));
          set_aw(p, (64'(p + 1) << 24) | 64'($urandom_range(0, 16'hFFFF)), ln,
                 3'($urandom_range(0, 3)), bt);
        end
        mst_resp[p].aw_ready = ($urandom_range(0, 3) != 0);
        if (!bv[p] && pend[p] > 0 && $urandom_range(0, 1) == 1) bv[p] = 1'b1;
        mst_resp[p].b_valid = bv[p];
        slv_req[p].b_ready  = ($urandom_range(0, 3) != 0);
      end
      inval_ready = ($urandom_range(0, 2) != 0);
      en          = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        aw_drop[p] = 1'b0;
        if (slv_resp[p].b_valid && slv_req[p].b_ready) begin
          bfwd[p]++;
          check($sformatf("b_before_done_p%0d", p), bfwd[p] <= done_m[p], 1);
        end
        if (mst_resp[p].b_valid && mst_req[p].b_ready) begin
          pend[p]--;
          bv[p] = 1'b0;
        end
        if (slv_req[p].aw_valid && slv_resp[p].aw_ready) begin
          model_push(p, slv_req[p].aw.addr, slv_req[p].aw.len, slv_req[p].aw.size,
                     slv_req[p].aw.burst, en);
          awcnt[p]++;
          pend[p]++;
          aw_drop[p] = 1'b1;
        end
      end
      if (inval_valid && inval_ready) model_ack(inval_addr);
      tick();
      for (int p = 0; p < NP; p++) if (aw_drop[p]) slv_req[p].aw_valid = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      check($sformatf("rnd_lines_left_p%0d", p), ql[p].size(), 0);
      check($sformatf("rnd_txns_left_p%0d", p), qc[p].size(), 0);
      check($sformatf("rnd_b_all_p%0d", p), bfwd[p], awcnt[p]);
    end
    check("rnd_some_traffic", (awcnt[0] > 10) && (awcnt[1] > 10), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_multi_inval_filter.md
Name: axi_multi_inval_filter

Overview:
- Multi-port, burst-aware successor to the system's single-port write-invalidation filter.
- Sits between NrPorts AXI write masters (vector unit, DMA, accelerators) and the system interconnect.
- For every AW burst accepted while coherence is enabled, it emits one invalidation per L1 D-cache line touched to the scalar core's invalidation port.
- It withholds each write response (B) until all invalidations for that transaction are acknowledged.

Parameters:
NrPorts, 2, number of independent AXI slave/master port pairs (1..8)
MaxTxns, 4, per-port depth of outstanding-transaction FIFO
AddrWidth, 64, AXI address width
L1LineWidth, 16, L1 D-cache line size in bytes (power of two)
aw_chan_t, logic, AXI AW channel struct
req_t, logic, AXI request struct
resp_t, logic, AXI response struct

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  coherence enable, sampled per AW handshake
slv_req_i  in  NrPorts x req_t  requests from upstream masters
slv_resp_o  out  NrPorts x resp_t  responses to upstream masters
mst_req_o  out  NrPorts x req_t  requests to interconnect
mst_resp_i  in  NrPorts x resp_t  responses from interconnect
inval_addr_o  out  AddrWidth  line-aligned invalidation address
inval_valid_o  out  1  invalidation request valid
inval_ready_i  in  1  invalidation accepted
busy_o  out  1  any FIFO non-empty or invalidation in flight

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - All FIFOs empty; done counters 0; FSM IDLE; round-robin pointer 0.
  - inval_valid_o=0, inval_addr_o=0, busy_o=0.
  - Reset mid-burst discards pending invalidations and withheld B responses.
- AR, R and W pass through combinationally per port.
- AW gating:
  - mst aw_valid = slv aw_valid & !fifo_full[p].
  - slv aw_ready = mst aw_ready & !fifo_full[p].
  - No added latency.
- On AW handshake, push {first_line, nlines, en_i} into FIFO[p].
  - Byte span by burst type: FIXED = 1<<size bytes from addr; INCR = (len+1)<<size bytes from addr; WRAP = (len+1)<<size bytes from addr aligned down to that size.
  - first_line = start >> log2(L1LineWidth).
  - nlines = (end_byte >> log2(L1LineWidth)) - first_line + 1.
  - nlines counter width is log2(256*128/L1LineWidth)+1; no truncation.
- Invalidation FSM:
  - IDLE:
    - Round-robin select lowest port index >= pointer with a non-empty FIFO.
    - If the head entry's en=0: pop it, done_cnt[p]++, stay in IDLE, no invalidation.
    - Else load line=first_line and remaining=nlines, go to ISSUE.
  - ISSUE:
    - inval_valid_o=1; inval_addr_o = line << log2(L1LineWidth).
    - Address and valid are held stable until inval_ready_i.
    - On ready with remaining>1: line++, remaining--, stay in ISSUE.
    - On ready with remaining==1: pop FIFO, done_cnt[p]++, pointer = p+1 mod NrPorts, go to IDLE.
  - One invalidation per cycle maximum; a 1-line transaction costs 2 cycles (IDLE + ISSUE).
- B gating per port:
  - slv b_valid = mst b_valid & (done_cnt[p]!=0).
  - mst b_ready = slv b_ready & (done_cnt[p]!=0).
  - Handshake decrements done_cnt[p]; simultaneous increment and decrement leaves it unchanged.
  - done_cnt width is log2(MaxTxns)+1.
- FIFO full: new AW stalled, no drop.
  - A full FIFO frees a slot on the cycle it pops; the AW is accepted on the next cycle (no same-cycle bypass).
- Line address wraps modulo 2^AddrWidth; no carry-out.
- en_i toggling affects only subsequently accepted AWs; in-flight entries keep their captured flag.
- busy_o = OR of FIFO non-empty | (state==ISSUE).

Test Plan:
1. Port0 AW addr=0x1008, INCR len=3 size=3, en_i=1 -> inval_addr_o 0x1000, 0x1010, 0x1020 on three consecutive ready cycles. B held until the third acknowledgment, then forwarded.
2. Port1 WRAP AW addr=0x2034 len=3 size=2, en_i=1 -> 16-byte window 0x2030; exactly one invalidation at 0x2030.
3. en_i=0, port0 AW (any) -> zero invalidations; B forwarded on the cycle after mst b_valid is seen with done_cnt=1.
4. Both ports AW same cycle (0x100 and 0x200, single line each), inval_ready_i=1 -> order 0x100 then 0x200, pointer advances. Repeat with port1 first in the FIFO -> fairness alternates.
5. MaxTxns=4, inval_ready_i=0, port0 issues 5 AWs -> fifth stalls (slv aw_ready=0). Raise ready -> fifth is accepted one cycle after the first pop.
6. Assert rst_i during ISSUE with remaining=2 -> next cycle inval_valid_o=0, busy_o=0, pending B not forwarded, FIFOs empty.
